// File: rtl/seq_mult_pkg.sv
// Shared types and sizing helpers for the sequential shift-add multiplier.
package seq_mult_pkg;

    // Controller states: accept in IDLE, WIDTH shift-add steps in RUN,
    // one sign-correction step in FIX.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } state_e;

    localparam int DEF_WIDTH = 16;

    // Iteration counter must be able to hold the value WIDTH itself.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

    localparam int DEF_CNT_W = cnt_width(DEF_WIDTH);

endpackage

// File: rtl/seq_mult_ctrl.sv
// FSM and iteration counter for seq_mult. All outputs except the
// accept strobe are registered.
module seq_mult_ctrl
    import seq_mult_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic   clk_i,
    input  logic   rst_i,
    input  logic   start_i,
    output state_e state_o,
    output logic   accept_o,
    output logic   run_o,
    output logic   fix_o,
    output logic   busy_o,
    output logic   done_o
);

    localparam int CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q;
    logic             done_q;

    // Sequencing: IDLE -> RUN (WIDTH cycles) -> FIX -> IDLE; done pulses once.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        state_q <= ST_RUN;
                        cnt_q   <= CNT_LOAD;
                        busy_q  <= 1'b1;
                    end
                end
                ST_RUN: begin
                    cnt_q <= cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        state_q <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                end
                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // A start is only honoured in IDLE; starts while busy are dropped here.
    assign accept_o = (state_q == ST_IDLE) && start_i;
    assign run_o    = (state_q == ST_RUN);
    assign fix_o    = (state_q == ST_FIX);
    assign state_o  = state_q;
    assign busy_o   = busy_q;
    assign done_o   = done_q;

endmodule

// File: rtl/seq_mult.sv
// Sequential shift-add multiplier, signed (sign-magnitude internally) or
// unsigned. One partial product per cycle, fixed latency WIDTH+2.
module seq_mult
    import seq_mult_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam logic [WIDTH-1:0]   ONE_W  = WIDTH'(1);
    localparam logic [2*WIDTH-1:0] ONE_2W = (2*WIDTH)'(1);

    state_e state;
    logic   accept, run, fix;

    seq_mult_ctrl #(.WIDTH(WIDTH)) u_ctrl (
        .clk_i    (clk),
        .rst_i    (rst),
        .start_i  (start),
        .state_o  (state),
        .accept_o (accept),
        .run_o    (run),
        .fix_o    (fix),
        .busy_o   (busy),
        .done_o   (done)
    );

    // Accumulator is {hi_q, lo_q}; lo_q starts as the multiplier and is
    // consumed LSB-first as product bits shift in from hi_q.
    logic [WIDTH-1:0]   mcand_q;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               neg_q;
    logic [2*WIDTH-1:0] product_q, product_d;

    logic [WIDTH-1:0]   a_mag, b_mag;
    logic               neg_d;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] acc;

    // Operand capture: magnitudes in signed mode. The most negative value
    // negates to itself, which read as unsigned is exactly its magnitude.
    always_comb begin
        a_mag = multiplicand;
        b_mag = multiplier;
        neg_d = 1'b0;
        if (signed_mode) begin
            if (multiplicand[WIDTH-1]) a_mag = ~multiplicand + ONE_W;
            if (multiplier[WIDTH-1])   b_mag = ~multiplier + ONE_W;
            neg_d = multiplicand[WIDTH-1] ^ multiplier[WIDTH-1];
        end
    end

    // One shift-add step: conditional add into the upper half with a carry
    // bit, then shift the {carry, hi, lo} chain right by one.
    always_comb begin
        sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
        hi_d = sum[WIDTH:1];
        lo_d = {sum[0], lo_q[WIDTH-1:1]};
    end

    // Sign correction applied once the magnitude product is complete.
    always_comb begin
        acc       = {hi_q, lo_q};
        product_d = neg_q ? (~acc + ONE_2W) : acc;
    end

    // Datapath registers: load on accept, iterate in RUN, publish in FIX.
    always_ff @(posedge clk) begin
        if (rst) begin
            mcand_q   <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            neg_q     <= 1'b0;
            product_q <= '0;
        end else begin
            if (accept) begin
                mcand_q <= a_mag;
                lo_q    <= b_mag;
                hi_q    <= '0;
                neg_q   <= neg_d;
            end else if (run) begin
                hi_q <= hi_d;
                lo_q <= lo_d;
            end
            if (fix) begin
                product_q <= product_d;
            end
        end
    end

    assign product = product_q;

`ifndef SYNTHESIS
    // FIX is the only state that may publish; state is otherwise unused here.
    always_ff @(posedge clk) begin
        if (!rst && done) begin
            assert (state == ST_IDLE);
        end
    end
`endif

endmodule

// File: tb/tb_seq_mult.sv
// Bench for seq_mult: directed WIDTH=16 scenarios plus randomised WIDTH=8
// and WIDTH=32 instances against an independent wide-multiply model.
module tb_seq_mult;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        start16 = 1'b0, sm16 = 1'b0;
    logic [15:0] a16 = '0, b16 = '0;
    logic        busy16, done16;
    logic [31:0] p16;

    logic        start8 = 1'b0, sm8 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        busy8, done8;
    logic [15:0] p8;

    logic        start32 = 1'b0, sm32 = 1'b0;
    logic [31:0] a32 = '0, b32 = '0;
    logic        busy32, done32;
    logic [63:0] p32;

    seq_mult #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .signed_mode(sm16),
        .multiplicand(a16), .multiplier(b16),
        .busy(busy16), .done(done16), .product(p16));
    seq_mult #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .signed_mode(sm8),
        .multiplicand(a8), .multiplier(b8),
        .busy(busy8), .done(done8), .product(p8));
    seq_mult #(.WIDTH(32)) dut32 (
        .clk(clk), .rst(rst), .start(start32), .signed_mode(sm32),
        .multiplicand(a32), .multiplier(b32),
        .busy(busy32), .done(done32), .product(p32));

    int tests_run = 0;
    int tests_failed = 0;
    int dcnt16 = 0;
    logic [63:0] exp16[$];
    logic [63:0] exp8[$];
    logic [63:0] exp32[$];

    always @(negedge clk) if (done16) dcnt16++;

    // Exact product modulo 2^(2w), operands sign-extended into 128 bits.
    function automatic logic [127:0] ref_mul(input int w, input bit sm,
                                             input logic [63:0] a, input logic [63:0] b);
        logic [127:0] ax, bx, m;
        ax = {64'd0, a};
        bx = {64'd0, b};
        if (sm && a[w-1]) ax = ax | ({128{1'b1}} << w);
        if (sm && b[w-1]) bx = bx | ({128{1'b1}} << w);
        m = (128'd1 << (2*w)) - 128'd1;
        return (ax * bx) & m;
    endfunction

    // Called right after a negedge; returns one negedge after the accepting edge.
    task automatic issue16(input bit sm, input logic [15:0] a, input logic [15:0] b,
                           input logic [31:0] e);
        sm16 = sm; a16 = a; b16 = b; start16 = 1'b1;
        exp16.push_back({32'd0, e});
        @(negedge clk);
        start16 = 1'b0;
    endtask

    // Waits for done (bounded), pops the scoreboard, checks product and latency.
    task automatic wait16(input string name, input int lat0);
        int lat;
        logic [63:0] e;
        lat = lat0;
        while (!done16 && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        tests_run++;
        if (!done16) begin
            tests_failed++;
            $display("FAIL %s: timeout, no done after %0d cycles", name, lat);
        end else begin
            e = (exp16.size() > 0) ? exp16.pop_front() : 64'hX;
            if (p16 !== e[31:0]) begin
                tests_failed++;
                $display("FAIL %s: product got %h expected %h", name, p16, e[31:0]);
            end
            tests_run++;
            if (lat !== 18) begin
                tests_failed++;
                $display("FAIL %s_latency: got %0d expected 18", name, lat);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        tests_run++;
        if ({busy16, done16, p16} !== 34'd0) begin
            tests_failed++;
            $display("FAIL reset16: busy=%b done=%b product=%h expected 0/0/0", busy16, done16, p16);
        end
        tests_run++;
        if ({busy8, done8, p8, busy32, done32, p32} !== 84'd0) begin
            tests_failed++;
            $display("FAIL reset8_32: p8=%h p32=%h busy=%b%b expected zeros", p8, p32, busy8, busy32);
        end
        // Start issued together with reset release: must be taken at that edge.
        rst = 1'b0;
        issue16(1'b0, 16'd130, 16'd1, 32'd130);
        tests_run++;
        if (busy16 !== 1'b1) begin
            tests_failed++;
            $display("FAIL first_start: busy got %b expected 1", busy16);
        end
        wait16("u130x1", 1);
    endtask

    task automatic test_back_to_back();
        int d0;
        @(negedge clk);
        d0 = dcnt16;
        issue16(1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001);
        wait16("uffff", 1);
        // Next op issued in the done cycle.
        issue16(1'b0, 16'd3, 16'd1, 32'd3);
        repeat (5) @(negedge clk);
        tests_run++;
        if (p16 !== 32'hFFFE0001) begin
            tests_failed++;
            $display("FAIL hold: product got %h expected fffe0001", p16);
        end
        wait16("b2b_3x1", 6);
        @(negedge clk);
        tests_run++;
        if (dcnt16 - d0 !== 2) begin
            tests_failed++;
            $display("FAIL b2b_dones: got %0d done pulses expected 2", dcnt16 - d0);
        end
    endtask

    task automatic test_signed();
        @(negedge clk);
        issue16(1'b1, 16'hFFFD, 16'd5, 32'hFFFFFFF1);
        wait16("s_m3x5", 1);
        @(negedge clk);
        issue16(1'b1, 16'h8000, 16'h8000, 32'h40000000);
        wait16("s_min_min", 1);
        @(negedge clk);
        issue16(1'b1, 16'h8000, 16'd1, 32'hFFFF8000);
        wait16("s_min_1", 1);
        @(negedge clk);
        issue16(1'b1, 16'hFFFB, 16'd0, 32'd0);
        wait16("s_m5x0", 1);
        @(negedge clk);
        issue16(1'b0, 16'h8000, 16'h8000, 32'h40000000);
        wait16("u_8000sq", 1);
    endtask

    task automatic test_busy_reject();
        int d0;
        @(negedge clk);
        d0 = dcnt16;
        issue16(1'b0, 16'd7, 16'd9, 32'd63);
        repeat (4) @(negedge clk);
        // RUN cycle 5: disturbing start plus operand/mode changes.
        a16 = 16'd2; b16 = 16'd2; sm16 = 1'b1; start16 = 1'b1;
        @(negedge clk);
        start16 = 1'b0; a16 = 16'hFFFF; b16 = 16'h1234;
        wait16("busy_reject", 6);
        repeat (25) @(negedge clk);
        tests_run++;
        if (dcnt16 - d0 !== 1 || busy16 !== 1'b0) begin
            tests_failed++;
            $display("FAIL busy_single_done: dones=%0d busy=%b expected 1/0", dcnt16 - d0, busy16);
        end
    endtask

    task automatic test_reset_mid();
        int d0;
        logic [63:0] dropped;
        @(negedge clk);
        d0 = dcnt16;
        issue16(1'b0, 16'd7, 16'd9, 32'd63);
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        dropped = exp16.pop_back();
        tests_run++;
        if ({busy16, done16, p16} !== 34'd0) begin
            tests_failed++;
            $display("FAIL mid_reset: busy=%b done=%b product=%h expected 0/0/0 (dropped %h)",
                     busy16, done16, p16, dropped[31:0]);
        end
        repeat (30) @(negedge clk);
        tests_run++;
        if (dcnt16 !== d0) begin
            tests_failed++;
            $display("FAIL mid_reset_nodone: dones=%0d expected 0", dcnt16 - d0);
        end
        issue16(1'b1, 16'hFFF9, 16'd9, 32'hFFFFFFC1);
        wait16("after_reset", 1);
    endtask

    task automatic test_rand8();
        logic [31:0]  r;
        logic [7:0]   a, b;
        bit           sm;
        logic [127:0] m;
        logic [63:0]  e;
        int           lat;
        for (int i = 0; i < 16; i++) begin
            r = $urandom; a = r[7:0]; b = r[15:8]; sm = r[16];
            if (i == 0) begin a = 8'h80; b = 8'h80; sm = 1'b1; end
            if (i == 1) begin a = 8'hFF; b = 8'hFF; sm = 1'b0; end
            if (i == 2) begin a = 8'h80; b = 8'h7F; sm = 1'b1; end
            @(negedge clk);
            sm8 = sm; a8 = a; b8 = b; start8 = 1'b1;
            m = ref_mul(8, sm, {56'd0, a}, {56'd0, b});
            exp8.push_back(m[63:0]);
            @(negedge clk);
            start8 = 1'b0; a8 = ~a; b8 = ~b; sm8 = ~sm;
            lat = 1;
            while (!done8 && lat < 40) begin @(negedge clk); lat++; end
            e = (exp8.size() > 0) ? exp8.pop_front() : 64'hX;
            tests_run++;
            if (!done8 || p8 !== e[15:0] || lat !== 10) begin
                tests_failed++;
                $display("FAIL w8_%0d: sm=%b a=%h b=%h product got %h expected %h latency %0d expected 10",
                         i, sm, a, b, p8, e[15:0], lat);
            end
        end
    endtask

    task automatic test_rand32();
        logic [31:0]  a, b;
        bit           sm;
        logic [127:0] m;
        logic [63:0]  e;
        int           lat;
        for (int i = 0; i < 12; i++) begin
            a = $urandom; b = $urandom; sm = i[0];
            if (i == 0) begin a = 32'h80000000; b = 32'h80000000; end
            if (i == 1) begin a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; end
            if (i == 2) begin a = 32'h80000000; b = 32'hFFFFFFFF; end
            @(negedge clk);
            sm32 = sm; a32 = a; b32 = b; start32 = 1'b1;
            m = ref_mul(32, sm, {32'd0, a}, {32'd0, b});
            exp32.push_back(m[63:0]);
            @(negedge clk);
            start32 = 1'b0; a32 = ~a; b32 = ~b; sm32 = ~sm;
            lat = 1;
            while (!done32 && lat < 80) begin @(negedge clk); lat++; end
            e = (exp32.size() > 0) ? exp32.pop_front() : 64'hX;
            tests_run++;
            if (!done32 || p32 !== e || lat !== 34) begin
                tests_failed++;
                $display("FAIL w32_%0d: sm=%b a=%h b=%h product got %h expected %h latency %0d expected 34",
                         i, sm, a, b, p32, e, lat);
            end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_back_to_back();
        test_signed();
        test_busy_reject();
        test_reset_mid();
        test_rand8();
        test_rand32();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/seq_mult.md
SEQ_MULT -- requirements
Module: seq_mult

Interface
REQ-001 Parameter WIDTH, default 16: operand width in bits; legal range 2..64.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 start  input  1  request a multiply; sampled on the rising clk edge.
REQ-005 signed_mode  input  1  1 = operands are two's complement, 0 = unsigned; sampled with start.
REQ-006 multiplicand  input  WIDTH  operand A; sampled with start.
REQ-007 multiplier  input  WIDTH  operand B; sampled with start.
REQ-008 busy  output  1  high while an operation is in progress.
REQ-009 done  output  1  one-cycle pulse marking product valid.
REQ-010 product  output  2*WIDTH  result; signed or unsigned per the captured signed_mode.

Function
REQ-011 States: IDLE, RUN, FIX; encoding is an implementation choice.
REQ-012 Accept: start=1 in IDLE at edge 0 captures the operands and signed_mode, sets busy=1 and enters RUN.
REQ-013 Capture, signed_mode=1: store |A| and |B| as WIDTH-bit unsigned; result sign = A[WIDTH-1] XOR B[WIDTH-1]. -2^(WIDTH-1) maps to magnitude 2^(WIDTH-1) without overflow.
REQ-014 Capture, signed_mode=0: operands stored unchanged; result sign = 0.
REQ-015 RUN iteration, one per edge, edges 1..WIDTH:
- if the multiplier LSB = 1, add the multiplicand to the upper half of the accumulator with a WIDTH+1-bit carry;
- then shift the accumulator/multiplier pair right by 1.
REQ-016 RUN lasts exactly WIDTH cycles regardless of operand values; no early termination on zero operands.
REQ-017 FIX, edge WIDTH+1:
- product <= two's-complement negation of the accumulator if result sign = 1, else the accumulator;
- busy <= 0, done <= 1, state <= IDLE.
REQ-018 Latency: done is high in exactly one cycle, the one following edge WIDTH+1; done = 0 at all other times.
REQ-019 product holds its value from the done cycle until the FIX of the next accepted operation; intermediate values never appear on product.
REQ-020 start while busy=1 is ignored; the in-flight operation and its operands are not disturbed.
REQ-021 start=1 in the done cycle is accepted (state is IDLE), giving back-to-back operations every WIDTH+2 cycles.
REQ-022 Input changes on multiplicand, multiplier or signed_mode after acceptance have no effect on the result.
REQ-023 product equals the exact mathematical product modulo 2^(2*WIDTH) for every operand pair in both modes.

Reset
REQ-024 rst=1 at a rising edge forces state=IDLE, busy=0, done=0, product=0, and clears the internal accumulator, operand registers and counter.
REQ-025 rst takes priority over start and over any in-flight operation; an operation interrupted by reset produces no done.
REQ-026 The first start is accepted at the first edge with rst=0.

Structure
REQ-027 Package seq_mult_pkg holds the state type and the iteration-counter width constant, clog2(WIDTH+1).
REQ-028 A single sub-module, seq_mult_ctrl, holds the FSM and iteration counter; the datapath (accumulator, adder, shifter, sign fix) stays in seq_mult.

Verification
REQ-029 WIDTH=16, unsigned, A=130, B=1 -> done 18 cycles after acceptance, product=130.
REQ-030 WIDTH=16, unsigned, A=0xFFFF, B=0xFFFF -> product=0xFFFE0001; A=3, B=1 issued in the done cycle -> product=3 exactly 18 cycles later.
REQ-031 WIDTH=16, signed:
- A=-3, B=5 -> product=0xFFFFFFF1;
- A=0x8000, B=0x8000 -> product=0x40000000;
- A=0x8000, B=1 -> product=0xFFFF8000.
REQ-032 Busy rejection: start A=7, B=9; pulse start with A=2, B=2 in RUN cycle 5 -> single done, product=63.
REQ-033 Reset mid-operation: assert rst in RUN cycle 8 -> next cycle busy=0, done=0, product=0; no done follows; a new start then completes normally.
REQ-034 WIDTH=8 and WIDTH=32 builds: randomised operands in both modes match a reference model, with latency WIDTH+2.
